// File: rtl/fir_mac_reader_if.sv
// Bus bundle for fir_mac_reader: delay-line/ROM read port, sample start strobe, output stream and status.
interface fir_mac_reader_if #(
  parameter int ADDR = 8
);
  logic            start_in;
  logic [11:0]     x_in;
  logic [15:0]     coef_in;
  logic [ADDR-1:0] addr_out;
  logic            rd_out;
  logic [15:0]     y_out;
  logic            y_valid_out;
  logic            busy_out;
  logic            overrun_out;

  modport master (
    input  start_in, x_in, coef_in,
    output addr_out, rd_out, y_out, y_valid_out, busy_out, overrun_out
  );

  modport slave (
    output start_in, x_in, coef_in,
    input  addr_out, rd_out, y_out, y_valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/fir_mac_reader.sv
// FIR delay-line read sequencer with MAC: sweeps N taps per start pulse, emits one saturated output.
// Build option FIR_READER_ROUND_EN: round-half-up before the output shift (default truncates).
module fir_mac_reader #(
  parameter int ADDR  = 8,
  parameter int N     = 256,
  parameter int SHIFT = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  fir_mac_reader_if.master bus
);
  localparam int ACC_W = 28 + ADDR;
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(N - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 16'h7FFF};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 16'h8000};
`ifdef FIR_READER_ROUND_EN
  localparam logic [ACC_W:0] RND_OFS = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
`else
  localparam logic [ACC_W:0] RND_OFS = {(ACC_W+1){1'b0}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR-1:0]         addr_r, addr_s;
  logic                    rd_r, rd_s;
  logic                    busy_r, busy_s;
  logic                    clr_acc_s, load_y_s;
  logic                    y_valid_r, overrun_r, tap_vld_r;
  logic [15:0]             y_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [11:0]      xs_s;
  logic signed [27:0]      prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W:0]   biased_s, shifted_s;

  function automatic logic [15:0] sat16(input logic signed [ACC_W:0] v);
    logic [15:0] r;
    if (v > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Offset-binary sample to signed, then full-precision tap product
  assign xs_s       = {~bus.x_in[11], bus.x_in[10:0]};
  assign prod_s     = xs_s * $signed(bus.coef_in);
  assign prod_ext_s = {{ADDR{prod_s[27]}}, prod_s};
  assign biased_s   = {acc_r[ACC_W-1], acc_r} + $signed(RND_OFS);
  assign shifted_s  = biased_s >>> SHIFT;

  // Sweep sequencing: next state and control strobes
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    rd_s      = rd_r;
    busy_s    = busy_r;
    clr_acc_s = 1'b0;
    load_y_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start_in) begin
          state_s   = FETCH;
          addr_s    = {ADDR{1'b0}};
          rd_s      = 1'b1;
          busy_s    = 1'b1;
          clr_acc_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (addr_r == LAST_ADDR) begin
          rd_s    = 1'b0;
          state_s = DRAIN;
        end else begin
          addr_s = addr_r + ADDR'(1);
        end
      end
      DRAIN: begin
        state_s = OUT;
      end
      OUT: begin
        load_y_s = 1'b1;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
        rd_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Control registers and sticky overrun flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR{1'b0}};
      rd_r      <= 1'b0;
      busy_r    <= 1'b0;
      y_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      rd_r      <= rd_s;
      busy_r    <= busy_s;
      y_valid_r <= load_y_s;
      overrun_r <= overrun_r | (bus.start_in & busy_r);
    end
  end

  // Accumulate one tap per cycle while read data is valid (one cycle behind rd)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tap_vld_r <= 1'b0;
      acc_r     <= {ACC_W{1'b0}};
      y_r       <= 16'h0000;
    end else begin
      tap_vld_r <= rd_r;
      if (clr_acc_s) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (tap_vld_r) begin
        acc_r <= acc_r + prod_ext_s;
      end else begin
        acc_r <= acc_r;
      end
      if (load_y_s) begin
        y_r <= sat16(shifted_s);
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign bus.addr_out    = addr_r;
  assign bus.rd_out      = rd_r;
  assign bus.y_out       = y_r;
  assign bus.y_valid_out = y_valid_r;
  assign bus.busy_out    = busy_r;
  assign bus.overrun_out = overrun_r;
endmodule

// File: tb/tb_fir_mac_reader.sv
// Scoreboard bench for fir_mac_reader: three configurations (N/SHIFT = 256/15, 4/0, 2/2) with directed vectors.
module tb_fir_mac_reader;
  localparam int NI = 3;
  localparam int NS [NI] = '{256, 4, 2};
  localparam int SH [NI] = '{15, 0, 2};

  typedef struct packed {
    logic [15:0] y;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_r [NI];
  logic [11:0] xmem [NI][256];
  logic [15:0] cmem [NI][256];
  exp_t        exp_q [NI][$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_run [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int inst, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d at cycle %0d", name, inst, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : u
    fir_mac_reader_if #(.ADDR(8)) bif ();
    fir_mac_reader #(.ADDR(8), .N(NS[g]), .SHIFT(SH[g])) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bif)
    );
    assign bif.start_in = start_r[g];

    // Registered delay-line buffer and coefficient ROM, one cycle latency
    always @(posedge clk) begin
      bif.x_in    <= xmem[g][bif.addr_out];
      bif.coef_in <= cmem[g][bif.addr_out];
    end

    int          run = 0;
    logic [15:0] held = 16'h0000;
    exp_t        e;

    // Monitor: address sequence, output hold, and scoreboard pop on y_valid
    always @(negedge clk) begin
      if (rst) begin
        run  = 0;
        held = 16'h0000;
      end else begin
        if (bif.rd_out) begin
          check(int'(bif.addr_out) == run, "addr_seq", g, int'(bif.addr_out), run);
          run++;
        end else if (run != 0) begin
          last_run[g] = run;
          run = 0;
        end
        if (bif.y_valid_out === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            check(1'b0, "spurious_y_valid", g, 1, 0);
          end else begin
            e = exp_q[g].pop_front();
            check(bif.y_out === e.y, "y_out", g, int'($signed(bif.y_out)), int'($signed(e.y)));
            check(cyc == int'(e.cyc), "y_valid_latency", g, cyc, int'(e.cyc));
            check(last_run[g] == NS[g], "rd_run_length", g, last_run[g], NS[g]);
            held = e.y;
          end
        end else begin
          check(bif.y_out === held, "y_hold", g, int'($signed(bif.y_out)), int'($signed(held)));
        end
      end
    end
  end

  task automatic sweep(input int g, input logic [15:0] y);
    exp_t e;
    @(posedge clk);
    #1;
    e.y   = y;
    e.cyc = 32'(cyc + NS[g] + 3);
    exp_q[g].push_back(e);
    start_r[g] = 1'b1;
    @(posedge clk);
    #1;
    start_r[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(n < 2000, "drain_timeout", -1, n, 2000);
  endtask

  task automatic run_one(input int g, input logic [15:0] y);
    sweep(g, y);
    wait_idle();
  endtask

  task automatic check_zero0(input string name);
    logic [27:0] act;
    act = {u[0].bif.y_out, u[0].bif.y_valid_out, u[0].bif.busy_out,
           u[0].bif.overrun_out, u[0].bif.rd_out, u[0].bif.addr_out};
    check(act === 28'd0, name, 0, act, 0);
  endtask

  task automatic fill(input int g, input logic [11:0] x, input logic [15:0] c);
    for (int i = 0; i < 256; i++) begin
      xmem[g][i] = x;
      cmem[g][i] = c;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] y_fine;
    logic [15:0] y_p6;
    logic [15:0] y_m6;
`ifdef FIR_READER_ROUND_EN
    y_fine = 16'd256;
    y_p6   = 16'd2;
    y_m6   = 16'hFFFF;
`else
    y_fine = 16'd255;
    y_p6   = 16'd1;
    y_m6   = 16'hFFFE;
`endif
    for (int g = 0; g < NI; g++) begin
      start_r[g]  = 1'b0;
      last_run[g] = 0;
      fill(g, 12'd2048, 16'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero0("reset_state");
    check(u[1].bif.busy_out === 1'b0 && u[2].bif.y_out === 16'h0000, "reset_state_others", 1, 0, 0);

    // Mid-scale samples give zero regardless of coefficients
    for (int i = 0; i < 256; i++) cmem[0][i] = 16'(i * 129 - 16000);
    run_one(0, 16'h0000);
    // Full-scale saturation both ways, then a small in-range result
    fill(0, 12'd4095, 16'd32767);
    run_one(0, 16'h7FFF);
    fill(0, 12'd0, 16'd32767);
    run_one(0, 16'h8000);
    fill(0, 12'd2049, 16'd32767);
    run_one(0, y_fine);

    fill(1, 12'd4095, 16'd1);
    run_one(1, 16'd8188);
    fill(1, 12'd0, 16'd1);
    run_one(1, 16'hE000);
    xmem[1][0] = 12'd4095; cmem[1][0] = 16'd1;
    xmem[1][1] = 12'd0;    cmem[1][1] = 16'd2;
    xmem[1][2] = 12'd2048; cmem[1][2] = 16'd3;
    xmem[1][3] = 12'd2049; cmem[1][3] = 16'hFFFB;
    run_one(1, 16'hF7FA);

    xmem[2][0] = 12'd2051; cmem[2][0] = 16'd2;
    xmem[2][1] = 12'd2048; cmem[2][1] = 16'd7;
    run_one(2, y_p6);
    xmem[2][0] = 12'd2045;
    run_one(2, y_m6);

    // Overrun: second start 10 cycles into a sweep is ignored but flagged
    check(u[0].bif.overrun_out === 1'b0, "overrun_clear", 0, u[0].bif.overrun_out, 0);
    sweep(0, y_fine);
    repeat (9) @(posedge clk);
    #1 start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    @(negedge clk);
    check(u[0].bif.overrun_out === 1'b1, "overrun_set", 0, u[0].bif.overrun_out, 1);
    check(u[0].bif.busy_out === 1'b1, "busy_during_sweep", 0, u[0].bif.busy_out, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    check(u[0].bif.overrun_out === 1'b1, "overrun_sticky", 0, u[0].bif.overrun_out, 1);
    check(u[0].bif.busy_out === 1'b0, "busy_idle", 0, u[0].bif.busy_out, 0);
    run_one(0, y_fine);
    check(u[0].bif.overrun_out === 1'b1, "overrun_sticky2", 0, u[0].bif.overrun_out, 1);

    // Reset 20 cycles into a sweep aborts it without an output
    sweep(0, y_fine);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    exp_q[0].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero0("reset_mid_sweep");
    repeat (300) @(negedge clk);
    check(u[0].bif.busy_out === 1'b0, "no_restart_after_reset", 0, u[0].bif.busy_out, 0);
    run_one(0, y_fine);
    check(u[0].bif.overrun_out === 1'b0, "overrun_after_reset", 0, u[0].bif.overrun_out, 0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
